// File: rtl/panel_run_ctrl_pkg.sv
// Shared definitions for the PDP-8 front-panel run controller:
// FSM state encodings, switch priority indices and the pulse arbiter.
package panel_run_ctrl_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int NUM_SW           = 8;

  // Switch indices in arbitration order, 0 = highest priority.
  localparam int IDX_STOP   = 0;
  localparam int IDX_START  = 1;
  localparam int IDX_CONT   = 2;
  localparam int IDX_STEPI  = 3;
  localparam int IDX_STEPC  = 4;
  localparam int IDX_LDADDR = 5;
  localparam int IDX_DEP    = 6;
  localparam int IDX_EXAM   = 7;

  typedef enum logic [2:0] {
    ST_HALTED    = 3'd0,
    ST_START_CLR = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_STOPPING  = 3'd3,
    ST_STEP_I    = 3'd4,
    ST_STEP_C    = 3'd5,
    ST_MEM_WAIT  = 3'd6
  } state_e;

  // Keep only the highest-priority (lowest index) pulse; all others are dropped.
  function automatic logic [NUM_SW-1:0] pick_pulse(input logic [NUM_SW-1:0] req);
    logic [NUM_SW-1:0] gnt;
    gnt = {NUM_SW{1'b0}};
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = {NUM_SW{1'b0}};
        gnt[i] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/panel_run_ctrl_debounce.sv
// One panel switch: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse on each accepted rising level.
module panel_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic ck_i,
  input  logic clear_n_i,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  // Count consecutive samples that disagree with the accepted level; flip it on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchroniser, debounce state and registered rising-edge pulse.
  always_ff @(posedge ck_i) begin
    if (!clear_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/panel_run_ctrl.sv
// Front-panel run controller: debounced switches drive a run/halt/step FSM
// and panel memory accesses (Load Address, Deposit, Examine) while halted.
module panel_run_ctrl
  import panel_run_ctrl_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic             CK,
  input  logic             CLEAR_N,
  input  logic             SW_START,
  input  logic             SW_STOP,
  input  logic             SW_CONT,
  input  logic             SW_STEPI,
  input  logic             SW_STEPC,
  input  logic             SW_LDADDR,
  input  logic             SW_DEP,
  input  logic             SW_EXAM,
  input  logic [WIDTH-1:0] SR,
  input  logic             INSTR_END,
  input  logic             CYCLE_END,
  input  logic             CPU_HLT,
  output logic             SEQ_RUN,
  output logic             SEQ_CLEAR,
  output logic             PC_LOAD,
  output logic [WIDTH-1:0] CPMA,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic             MEM_ACK,
  input  logic [WIDTH-1:0] MEM_RDATA,
  output logic [WIDTH-1:0] MB_DISP,
  output logic             RUN_LAMP
);

  logic [NUM_SW-1:0] sw_raw_s, pulse_s, win_s;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cpma_q, cpma_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              run_q, run_d;
  logic              clr_q, clr_d;

  assign sw_raw_s = {SW_EXAM, SW_DEP, SW_LDADDR, SW_STEPC,
                     SW_STEPI, SW_CONT, SW_START, SW_STOP};

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    panel_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .ck_i      (CK),
      .clear_n_i (CLEAR_N),
      .raw_i     (sw_raw_s[g]),
      .pulse_o   (pulse_s[g])
    );
  end

  assign win_s = pick_pulse(pulse_s);

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cpma_d  = cpma_q;
    mb_d    = mb_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      ST_HALTED: begin
        if (win_s[IDX_START]) begin
          state_d = ST_START_CLR;
        end else if (win_s[IDX_CONT]) begin
          state_d = ST_RUNNING;
        end else if (win_s[IDX_STEPI]) begin
          state_d = ST_STEP_I;
        end else if (win_s[IDX_STEPC]) begin
          state_d = ST_STEP_C;
        end else if (win_s[IDX_LDADDR]) begin
          cpma_d = SR;
        end else if (win_s[IDX_DEP]) begin
          wdata_d = SR;
          we_d    = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (win_s[IDX_EXAM]) begin
          we_d    = 1'b0;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_START_CLR: state_d = ST_RUNNING;
      ST_RUNNING: begin
        if (CPU_HLT) begin
          state_d = ST_HALTED;
        end else if (win_s[IDX_STOP]) begin
          state_d = ST_STOPPING;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_STOPPING, ST_STEP_I: begin
        if (INSTR_END || CPU_HLT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = state_q;
        end
      end
      ST_STEP_C: begin
        if (CYCLE_END || INSTR_END || CPU_HLT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP_C;
        end
      end
      ST_MEM_WAIT: begin
        // An acknowledge only counts once the request is actually on the bus.
        if (req_q && MEM_ACK) begin
          mb_d    = we_q ? wdata_q : MEM_RDATA;
          cpma_d  = cpma_q + WIDTH'(1);
          state_d = ST_HALTED;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    run_d = (state_d == ST_RUNNING) || (state_d == ST_STOPPING) ||
            (state_d == ST_STEP_I)  || (state_d == ST_STEP_C);
    clr_d = (state_d == ST_START_CLR);
    req_d = (state_q == ST_MEM_WAIT) && (state_d == ST_MEM_WAIT);
  end

  // State and output registers; reset also drops any outstanding request.
  always_ff @(posedge CK) begin
    if (!CLEAR_N) begin
      state_q <= ST_HALTED;
      cpma_q  <= {WIDTH{1'b0}};
      mb_q    <= {WIDTH{1'b0}};
      wdata_q <= {WIDTH{1'b0}};
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cpma_q  <= cpma_d;
      mb_q    <= mb_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
    end
  end

  assign SEQ_RUN   = run_q;
  assign RUN_LAMP  = run_q;
  assign SEQ_CLEAR = clr_q;
  assign PC_LOAD   = clr_q;
  assign CPMA      = cpma_q;
  assign MB_DISP   = mb_q;
  assign MEM_REQ   = req_q;
  assign MEM_WE    = we_q;
  assign MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_panel_run_ctrl.sv
// Directed bench for panel_run_ctrl with DEBOUNCE=4 and hand-computed expectations.
module tb_panel_run_ctrl;
  import panel_run_ctrl_pkg::*;

  logic        CK;
  logic        CLEAR_N;
  logic [7:0]  sw_s;
  logic [11:0] SR;
  logic        INSTR_END, CYCLE_END, CPU_HLT;
  logic        SEQ_RUN, SEQ_CLEAR, PC_LOAD, MEM_REQ, MEM_WE, RUN_LAMP, MEM_ACK;
  logic [11:0] CPMA, MEM_WDATA, MEM_RDATA, MB_DISP;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt  = 0;

  panel_run_ctrl #(.WIDTH(12), .DEBOUNCE(4)) dut (
    .CK(CK), .CLEAR_N(CLEAR_N),
    .SW_START(sw_s[IDX_START]), .SW_STOP(sw_s[IDX_STOP]), .SW_CONT(sw_s[IDX_CONT]),
    .SW_STEPI(sw_s[IDX_STEPI]), .SW_STEPC(sw_s[IDX_STEPC]), .SW_LDADDR(sw_s[IDX_LDADDR]),
    .SW_DEP(sw_s[IDX_DEP]), .SW_EXAM(sw_s[IDX_EXAM]),
    .SR(SR), .INSTR_END(INSTR_END), .CYCLE_END(CYCLE_END), .CPU_HLT(CPU_HLT),
    .SEQ_RUN(SEQ_RUN), .SEQ_CLEAR(SEQ_CLEAR), .PC_LOAD(PC_LOAD), .CPMA(CPMA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .MB_DISP(MB_DISP), .RUN_LAMP(RUN_LAMP)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Count every cycle in which the sequencer clear is asserted.
  always @(posedge CK) begin
    if (SEQ_CLEAR) clr_cnt <= clr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0o exp %0o", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Raw press: the pulse is acted on at the 8th edge, and the raw line is then released.
  task automatic press(input int idx);
    sw_s[idx] = 1'b1;
    tick(8);
    sw_s[idx] = 1'b0;
  endtask

  initial begin
    CLEAR_N = 1'b0; sw_s = 8'd0; SR = 12'd0;
    INSTR_END = 1'b0; CYCLE_END = 1'b0; CPU_HLT = 1'b0;
    MEM_ACK = 1'b0; MEM_RDATA = 12'd0;
    tick(3);
    check_eq("rst_run", 32'(SEQ_RUN), 32'd0);
    check_eq("rst_clr", 32'(SEQ_CLEAR), 32'd0);
    check_eq("rst_pcl", 32'(PC_LOAD), 32'd0);
    check_eq("rst_cpma", 32'(CPMA), 32'd0);
    check_eq("rst_req", 32'(MEM_REQ), 32'd0);
    check_eq("rst_mb", 32'(MB_DISP), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'd0);
    CLEAR_N = 1'b1;

    // Load address then START, with exact pulse timing.
    SR = 12'o0200;
    press(IDX_LDADDR);
    check_eq("ld_cpma", 32'(CPMA), 32'o0200);
    check_eq("ld_run", 32'(SEQ_RUN), 32'd0);
    sw_s[IDX_START] = 1'b1;
    tick(7);
    check_eq("st_clr_early", 32'(SEQ_CLEAR), 32'd0);
    tick(1);
    check_eq("st_clr", 32'(SEQ_CLEAR), 32'd1);
    check_eq("st_pcl", 32'(PC_LOAD), 32'd1);
    check_eq("st_run0", 32'(SEQ_RUN), 32'd0);
    sw_s[IDX_START] = 1'b0;
    tick(1);
    check_eq("st_clr_end", 32'(SEQ_CLEAR), 32'd0);
    check_eq("st_pcl_end", 32'(PC_LOAD), 32'd0);
    check_eq("st_run1", 32'(SEQ_RUN), 32'd1);
    check_eq("st_lamp", 32'(RUN_LAMP), 32'd1);
    check_eq("st_clr_cnt", 32'(clr_cnt), 32'd1);

    // STOP finishes the current instruction.
    press(IDX_STOP);
    check_eq("sp_run", 32'(SEQ_RUN), 32'd1);
    check_eq("sp_state", 32'(dut.state_q), 32'd3);
    tick(4);
    INSTR_END = 1'b1;
    check_eq("sp_run_ie", 32'(SEQ_RUN), 32'd1);
    tick(1);
    INSTR_END = 1'b0;
    check_eq("sp_run_off", 32'(SEQ_RUN), 32'd0);
    check_eq("sp_halted", 32'(dut.state_q), 32'd0);

    // CONT, HLT, CONT again without a clear.
    press(IDX_CONT);
    check_eq("ct_run", 32'(SEQ_RUN), 32'd1);
    CPU_HLT = 1'b1;
    tick(1);
    CPU_HLT = 1'b0;
    check_eq("hlt_run", 32'(SEQ_RUN), 32'd0);
    tick(8);
    press(IDX_CONT);
    check_eq("ct2_run", 32'(SEQ_RUN), 32'd1);
    check_eq("ct2_clr_cnt", 32'(clr_cnt), 32'd1);
    CPU_HLT = 1'b1;
    tick(1);
    CPU_HLT = 1'b0;
    check_eq("hlt2_run", 32'(SEQ_RUN), 32'd0);

    // Deposit at 7777 wraps CPMA to 0000.
    SR = 12'o7777;
    press(IDX_LDADDR);
    check_eq("dp_cpma0", 32'(CPMA), 32'o7777);
    SR = 12'o1234;
    press(IDX_DEP);
    SR = 12'o4321;
    check_eq("dp_req_entry", 32'(MEM_REQ), 32'd0);
    tick(1);
    check_eq("dp_req", 32'(MEM_REQ), 32'd1);
    check_eq("dp_we", 32'(MEM_WE), 32'd1);
    check_eq("dp_wdata", 32'(MEM_WDATA), 32'o1234);
    tick(1);
    MEM_ACK = 1'b1;
    check_eq("dp_req_ack", 32'(MEM_REQ), 32'd1);
    tick(1);
    MEM_ACK = 1'b0;
    check_eq("dp_req_off", 32'(MEM_REQ), 32'd0);
    check_eq("dp_mb", 32'(MB_DISP), 32'o1234);
    check_eq("dp_cpma_wrap", 32'(CPMA), 32'o0000);

    // Examine at 0000.
    MEM_RDATA = 12'o5670;
    press(IDX_EXAM);
    tick(1);
    check_eq("ex_req", 32'(MEM_REQ), 32'd1);
    check_eq("ex_we", 32'(MEM_WE), 32'd0);
    MEM_ACK = 1'b1;
    tick(1);
    MEM_ACK = 1'b0;
    MEM_RDATA = 12'o0000;
    check_eq("ex_mb", 32'(MB_DISP), 32'o5670);
    check_eq("ex_cpma", 32'(CPMA), 32'o0001);
    check_eq("ex_req_off", 32'(MEM_REQ), 32'd0);

    // A stray acknowledge while halted changes nothing.
    MEM_RDATA = 12'o1111;
    MEM_ACK = 1'b1;
    tick(1);
    MEM_ACK = 1'b0;
    MEM_RDATA = 12'o0000;
    check_eq("stray_mb", 32'(MB_DISP), 32'o5670);
    check_eq("stray_cpma", 32'(CPMA), 32'o0001);

    // STEPI and DEP in the same cycle: only the step is taken.
    SR = 12'o0777;
    sw_s[IDX_STEPI] = 1'b1;
    sw_s[IDX_DEP] = 1'b1;
    tick(8);
    sw_s[IDX_STEPI] = 1'b0;
    sw_s[IDX_DEP] = 1'b0;
    check_eq("sim_run", 32'(SEQ_RUN), 32'd1);
    check_eq("sim_state", 32'(dut.state_q), 32'd4);
    tick(2);
    check_eq("sim_req", 32'(MEM_REQ), 32'd0);
    check_eq("sim_wdata", 32'(MEM_WDATA), 32'o1234);
    INSTR_END = 1'b1;
    tick(1);
    INSTR_END = 1'b0;
    check_eq("si_run_off", 32'(SEQ_RUN), 32'd0);
    check_eq("si_halted", 32'(dut.state_q), 32'd0);

    // STEPC completes on a CYCLE_END in its very first cycle.
    press(IDX_STEPC);
    CYCLE_END = 1'b1;
    check_eq("sc_run", 32'(SEQ_RUN), 32'd1);
    tick(1);
    CYCLE_END = 1'b0;
    check_eq("sc_run_off", 32'(SEQ_RUN), 32'd0);

    // A 3-cycle glitch on START is rejected.
    sw_s[IDX_START] = 1'b1;
    tick(3);
    sw_s[IDX_START] = 1'b0;
    tick(12);
    check_eq("gl_clr_cnt", 32'(clr_cnt), 32'd1);
    check_eq("gl_run", 32'(SEQ_RUN), 32'd0);
    check_eq("gl_state", 32'(dut.state_q), 32'd0);

    // Reset while a request is outstanding; a late ack is ignored.
    press(IDX_EXAM);
    tick(1);
    check_eq("rm_req", 32'(MEM_REQ), 32'd1);
    CLEAR_N = 1'b0;
    tick(1);
    check_eq("rm_req_off", 32'(MEM_REQ), 32'd0);
    check_eq("rm_cpma", 32'(CPMA), 32'd0);
    check_eq("rm_state", 32'(dut.state_q), 32'd0);
    check_eq("rm_mb", 32'(MB_DISP), 32'd0);
    CLEAR_N = 1'b1;
    MEM_RDATA = 12'o3333;
    MEM_ACK = 1'b1;
    tick(1);
    MEM_ACK = 1'b0;
    MEM_RDATA = 12'o0000;
    tick(1);
    check_eq("late_cpma", 32'(CPMA), 32'd0);
    check_eq("late_mb", 32'(MB_DISP), 32'd0);
    check_eq("late_req", 32'(MEM_REQ), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/panel_run_ctrl.md
Name: panel_run_ctrl

Overview:
Front-panel run controller for the PDP-8 core. It debounces the momentary panel switches and runs a run/halt/step state machine that drives the instruction sequencer's run and clear inputs. It also sequences panel memory accesses (Load Address, Deposit, Examine) through a req/ack handshake while the CPU is halted. It sits between the panel switch inputs and both the sequencer and the memory arbiter.

Parameters:
WIDTH, 12, data/address word width
DEBOUNCE, 16, consecutive stable cycles required before a switch level is accepted (minimum 1)

Ports:
CK  in  1  system clock; all state changes on its rising edge
CLEAR_N  in  1  reset; synchronous, active-low
SW_START, SW_STOP, SW_CONT, SW_STEPI, SW_STEPC, SW_LDADDR, SW_DEP, SW_EXAM  in  1 each  raw momentary switches, active-high, asynchronous
SR  in  WIDTH  switch register
INSTR_END  in  1  sequencer pulse: current instruction completed
CYCLE_END  in  1  sequencer pulse: current major cycle completed
CPU_HLT  in  1  pulse: HLT instruction executed
SEQ_RUN  out  1  level; sequencer may advance while high
SEQ_CLEAR  out  1  one-cycle pulse; clears sequencer, AC, and L
PC_LOAD  out  1  one-cycle pulse; CPU loads PC from CPMA
CPMA  out  WIDTH  panel memory address register
MEM_REQ  out  1  panel memory request
MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ
MEM_WDATA  out  WIDTH  write data (SR captured at request)
MEM_ACK  in  1  one-cycle acknowledge from the memory arbiter
MEM_RDATA  in  WIDTH  read data, valid in the MEM_ACK cycle
MB_DISP  out  WIDTH  last examined or deposited word
RUN_LAMP  out  1  equals SEQ_RUN

Behaviour:
- Reset (CLEAR_N=0 at an edge):
  - State goes to HALTED.
  - All outputs become 0, including CPMA and MB_DISP.
  - Synchronisers and debounce counters become 0.
  - Reset in the middle of a memory access drops MEM_REQ at that same edge. No increment occurs.
- Switch front end, per switch:
  - 2-flop synchroniser, then a stable-level counter.
  - The accepted level updates after DEBOUNCE consecutive equal samples.
  - Rising edge of the accepted level gives a one-cycle pulse.
  - Pulse appears DEBOUNCE+3 cycles after a clean raw rise.
  - Glitches shorter than DEBOUNCE cycles produce no pulse.
- Arbitration of same-cycle pulses, highest first: STOP > START > CONT > STEPI > STEPC > LDADDR > DEP > EXAM.
  - Exactly one pulse is acted on; the others are discarded.
  - Pulses the current state does not accept are discarded, never queued.
- FSM states: HALTED, START_CLR, RUNNING, STOPPING, STEP_I, STEP_C, MEM_WAIT.
  - HALTED:
    - START -> START_CLR.
    - CONT -> RUNNING.
    - STEPI -> STEP_I.
    - STEPC -> STEP_C.
    - LDADDR: CPMA <= SR, stay in HALTED.
    - DEP: MEM_WDATA <= SR, MEM_WE=1 -> MEM_WAIT.
    - EXAM: MEM_WE=0 -> MEM_WAIT.
    - STOP is ignored.
  - START_CLR, one cycle: SEQ_CLEAR=1 and PC_LOAD=1 -> RUNNING.
  - RUNNING:
    - SEQ_RUN=1.
    - CPU_HLT -> HALTED.
    - STOP -> STOPPING.
    - All other switches are ignored.
  - STOPPING:
    - SEQ_RUN=1 until INSTR_END or CPU_HLT, then -> HALTED.
    - SEQ_RUN is 0 from the following cycle.
  - STEP_I: SEQ_RUN=1 until INSTR_END or CPU_HLT -> HALTED. STOP is ignored; the step always completes.
  - STEP_C: SEQ_RUN=1 until CYCLE_END, INSTR_END or CPU_HLT -> HALTED.
  - MEM_WAIT:
    - MEM_REQ=1 from the cycle after entry; MEM_WE and MEM_WDATA are held stable.
    - In the MEM_ACK cycle:
      - Read: MB_DISP <= MEM_RDATA.
      - Write: MB_DISP <= MEM_WDATA.
      - CPMA <= CPMA+1 modulo 2^WIDTH (7777 wraps to 0000).
      - State -> HALTED; MEM_REQ is 0 from the next cycle.
    - There is no timeout.
    - All switch pulses are ignored.
- SEQ_RUN is a registered output, with no combinational path from any input.
- INSTR_END or CYCLE_END arriving in the same cycle as state entry counts as completion.
- MEM_ACK outside MEM_WAIT is ignored.

Decomposition:
- Shared include panel_defs.vh:
  - state encodings (localparam, 3-bit);
  - switch index constants 0..7 in priority order;
  - DEBOUNCE default.
- One sub-module, panel_debounce (synchroniser, counter, edge pulse; parameter DEBOUNCE), instantiated 8 times.
- The FSM and datapath registers live in panel_run_ctrl.

Test Plan:
All scenarios use DEBOUNCE=4.
- Reset then START:
  - SR=0200, press LDADDR, then START.
  - Required: CPMA=0200; SEQ_CLEAR and PC_LOAD each high exactly one cycle; SEQ_RUN=1 the next cycle; pulse occurs 7 cycles after the raw switch rise.
- Stop:
  - While RUNNING, press STOP and assert INSTR_END 5 cycles later.
  - Required: SEQ_RUN stays 1 through the INSTR_END cycle, is 0 after it, state is HALTED.
- HLT while running: CPU_HLT pulse while RUNNING -> SEQ_RUN=0 next cycle. A subsequent CONT resumes with no SEQ_CLEAR.
- Deposit then examine, with wrap-around:
  - CPMA=7777, SR=1234, DEP, ACK after 3 cycles.
  - Required: MEM_WE=1, MEM_WDATA=1234, MB_DISP=1234, CPMA=0000.
  - Then EXAM with MEM_RDATA=5670. Required: MB_DISP=5670, CPMA=0001.
- Simultaneous switches and glitches:
  - STEPI and DEP accepted in the same cycle while HALTED -> STEP_I only, no MEM_REQ.
  - 3-cycle raw glitch on START -> no pulse.
- Reset mid-operation:
  - CLEAR_N=0 while MEM_REQ=1.
  - Required: MEM_REQ=0, CPMA unchanged-to-0, state HALTED after that edge; a late MEM_ACK is ignored.
